mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares the single RAM port between three requesters: instruction fetch from core 0, instruction fetch from core 1, and the coherent data port driven by the bus controller.
- Sits between the cache/bus layer and the RAM model.
- Locks one grant per access and latches the request, so the RAM sees stable signals.
- Data port has fixed priority; instruction ports rotate round-robin; a starvation limit guarantees instruction progress.

Parameters:
- STARVE_LIMIT, 4: consecutive data grants allowed while any instruction request is pending.
- TIMEOUT_CYCLES, 1024: RAM wait cycles in one access before the sticky error flag sets.

Ports:
- CLK  in  1  clock
- RST  in  1  reset, asynchronous, active-high
- iREN  in  2  instruction read request, one bit per core
- iaddr  in  2x32  instruction address per core (word_t)
- iwait  out  2  instruction wait per core; low for exactly one cycle on completion
- iload  out  2x32  instruction data; valid when matching iwait is low
- dREN  in  1  data read request from bus controller
- dWEN  in  1  data write request from bus controller
- daddr  in  32  data address
- dstore  in  32  data write value
- dwait  out  1  data wait; low for one cycle on completion
- dload  out  32  data read value; valid when dwait is low
- ramREN  out  1  RAM read enable
- ramWEN  out  1  RAM write enable
- ramaddr  out  32  RAM address
- ramstore  out  32  RAM write data
- ramload  in  32  RAM read data
- ramwait  in  1  RAM busy; low means access completes this cycle
- timeout_err  out  1  sticky timeout flag

Behaviour:
- Reset values: state IDLE; rr_ptr 0; starve_cnt 0; timeout counter 0; timeout_err 0; all latches 0.
  - ramREN/ramWEN 0 immediately (async); iwait 2'b11; dwait 1; iload/dload 0.
- Unsupported request: dREN and dWEN both high. The write wins (dWEN treated as write, dREN ignored).
- States:
  - IDLE: arbitrate (below). On a grant, latch owner, addr, store and rw into registers; next state ACCESS. With no request, stay in IDLE.
  - ACCESS: drive the RAM only from the latches. When ramwait is low, drive the owner's wait low that same cycle and place ramload on the owner's load bus; next state IDLE.
- Arbitration order:
  1. If starve_cnt equals STARVE_LIMIT and any iREN is high, grant an instruction port.
  2. Otherwise, if dREN or dWEN is high, grant data.
  3. Otherwise grant an instruction port.
- Instruction pick: the port at rr_ptr if requesting, else the other port.
  - On each instruction grant, rr_ptr becomes the granted index inverted.
- starve_cnt:
  - Increments (saturating at STARVE_LIMIT) on a data grant while any iREN is high.
  - Clears on any instruction grant.
  - Clears when no iREN is high in IDLE.
- Latency: request seen in IDLE at cycle N gives RAM enables at N+1. With ramwait low at N+1, wait drops at N+1. One bubble cycle (IDLE) always separates accesses.
- Wait outputs: non-owner waits stay high at all times. Owner wait is high except in the completion cycle.
- Requester drops its request mid-access: the RAM access still finishes (writes still commit). The completion pulse is still issued and ignored upstream. Requests must be held until wait goes low.
- Timeout:
  - The counter counts ACCESS cycles with ramwait high.
  - Reaching TIMEOUT_CYCLES sets timeout_err (sticky until RST); the access continues to wait.
  - The counter clears on each grant.
- Reset mid-ACCESS: RAM enables deassert asynchronously; no completion pulse is issued; the access is abandoned.
- Address/data widths: pass-through, no alignment checks.

Decomposition:
- Add to cpu_types_pkg: arb_owner_t enum {OWN_I0, OWN_I1, OWN_D}; arb_state_t enum {IDLE, ACCESS}.
- Reuse word_t from cpu_types_pkg.
- One sub-module, rr_picker: 2-input round-robin pick plus pointer update. Pure function of the request vector and rr_ptr; the pointer register is owned by the parent.

Test Plan:
- iREN=2'b01, iaddr[0]=0x100, ramwait low on first ACCESS cycle -> ramREN=1, ramaddr=0x100 at cycle 1; iwait[0]=0 and iload[0]=ramload at cycle 1; back in IDLE at cycle 2.
- iREN=2'b11 held, ramwait=0 -> grants alternate I0, I1, I0, I1 over 4 accesses; an iwait pulse every 2 cycles.
- dREN=1 held continuously, iREN=2'b01 held, STARVE_LIMIT=4 -> grants D, D, D, D, I0, D, ...
- dWEN=1, daddr=0x200, dstore=0xDEADBEEF, ramwait high 3 cycles -> ramWEN, ramaddr and ramstore stable for 4 cycles; dwait low only in the 4th; dREN toggling during the access has no effect.
- TIMEOUT_CYCLES=8, ramwait stuck high -> timeout_err rises after the 8th wait cycle and stays high; dwait stays high.
- RST pulsed in the middle of ACCESS -> ramREN/ramWEN low in the same cycle; no wait pulse; state IDLE; timeout_err 0.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU types: word type plus memory
// arbiter owner and state encodings.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    OWN_I0 = 2'd0,
    OWN_I1 = 2'd1,
    OWN_D  = 2'd2
  } arb_owner_t;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } arb_state_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester and RAM side signals of the
// memory arbiter, bundled with modports.
interface mem_arbiter_if;
  import cpu_types_pkg::*;

  logic [1:0]  iREN;
  word_t [1:0] iaddr;
  logic [1:0]  iwait;
  word_t [1:0] iload;
  logic        dREN;
  logic        dWEN;
  word_t       daddr;
  word_t       dstore;
  logic        dwait;
  word_t       dload;
  logic        ramREN;
  logic        ramWEN;
  word_t       ramaddr;
  word_t       ramstore;
  word_t       ramload;
  logic        ramwait;
  logic        timeout_err;

  modport slave (
    input  iREN, iaddr, dREN, dWEN,
    input  daddr, dstore,
    input  ramload, ramwait,
    output iwait, iload, dwait, dload,
    output ramREN, ramWEN,
    output ramaddr, ramstore,
    output timeout_err
  );

  modport master (
    output iREN, iaddr, dREN, dWEN,
    output daddr, dstore,
    output ramload, ramwait,
    input  iwait, iload, dwait, dload,
    input  ramREN, ramWEN,
    input  ramaddr, ramstore,
    input  timeout_err
  );

endinterface

// File: rtl/rr_picker.sv
// Two-way round-robin pick; the pointer
// register itself lives in the parent.
module rr_picker (
  input  logic [1:0] i_req,
  input  logic       i_ptr,
  output logic       o_pick,
  output logic       o_ptr_nxt
);

  assign o_pick    = i_req[i_ptr] ? i_ptr : ~i_ptr;
  assign o_ptr_nxt = ~o_pick;

endmodule

// File: rtl/mem_arbiter.sv
// Shares one RAM port between two fetch
// ports and the data port, one access at a time.
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int STARVE_LIMIT   = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic CLK,
  input  logic RST,
  mem_arbiter_if.slave bus
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [SW-1:0] ST_MAX =
    SW'(STARVE_LIMIT);
  localparam logic [TW-1:0] TO_MAX =
    TW'(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TO_LAST =
    TW'(TIMEOUT_CYCLES - 1);

  arb_state_t r_state;
  arb_owner_t r_owner;
  word_t      r_addr;
  word_t      r_store;
  logic       r_wr;
  logic       r_rr_ptr;
  logic [SW-1:0] r_starve;
  logic [TW-1:0] r_to_cnt;
  logic       r_to_err;

  logic w_idle;
  logic w_access;
  logic w_any_i;
  logic w_any_d;
  logic w_grant_i;
  logic w_grant_d;
  logic w_pick;
  logic w_ptr_nxt;
  logic w_done;
  logic [1:0] w_iwait;

  rr_picker u_rr (
    .i_req     (bus.iREN),
    .i_ptr     (r_rr_ptr),
    .o_pick    (w_pick),
    .o_ptr_nxt (w_ptr_nxt)
  );

  assign w_idle   = (r_state == IDLE);
  assign w_access = (r_state == ACCESS);
  assign w_any_i  = |bus.iREN;
  assign w_any_d  = bus.dREN | bus.dWEN;

  // Starved fetch beats data; else data first.
  assign w_grant_i = w_idle && w_any_i &&
    ((r_starve == ST_MAX) || !w_any_d);
  assign w_grant_d = w_idle && w_any_d &&
    !w_grant_i;

  // FSM and request latches for the access.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= IDLE;
      r_owner <= OWN_I0;
      r_addr  <= '0;
      r_store <= '0;
      r_wr    <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_grant_i) begin
            r_owner <= w_pick ? OWN_I1 : OWN_I0;
            r_addr  <= bus.iaddr[w_pick];
            r_store <= '0;
            r_wr    <= 1'b0;
            r_state <= ACCESS;
          end else if (w_grant_d) begin
            r_owner <= OWN_D;
            r_addr  <= bus.daddr;
            r_store <= bus.dstore;
            r_wr    <= bus.dWEN;
            r_state <= ACCESS;
          end
        end
        ACCESS: begin
          if (!bus.ramwait) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Round-robin pointer and starvation count.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_rr_ptr <= 1'b0;
      r_starve <= '0;
    end else if (w_grant_i) begin
      r_rr_ptr <= w_ptr_nxt;
      r_starve <= '0;
    end else if (w_idle && !w_any_i) begin
      r_starve <= '0;
    end else if (w_grant_d && r_starve != ST_MAX) begin
      r_starve <= r_starve + SW'(1);
    end
  end

  // RAM stall counter and sticky timeout flag.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_to_cnt <= '0;
      r_to_err <= 1'b0;
    end else if (w_grant_i || w_grant_d) begin
      r_to_cnt <= '0;
    end else if (w_access && bus.ramwait &&
                 r_to_cnt != TO_MAX) begin
      r_to_cnt <= r_to_cnt + TW'(1);
      if (r_to_cnt == TO_LAST) r_to_err <= 1'b1;
    end
  end

  assign w_done = w_access && !bus.ramwait;

  assign w_iwait[0] = !(w_done && r_owner == OWN_I0);
  assign w_iwait[1] = !(w_done && r_owner == OWN_I1);

  assign bus.iwait    = w_iwait;
  assign bus.iload[0] = w_iwait[0] ? '0 : bus.ramload;
  assign bus.iload[1] = w_iwait[1] ? '0 : bus.ramload;
  assign bus.dwait    = !(w_done && r_owner == OWN_D);
  assign bus.dload    = bus.dwait ? '0 : bus.ramload;

  assign bus.ramREN   = w_access && !r_wr;
  assign bus.ramWEN   = w_access && r_wr;
  assign bus.ramaddr  = r_addr;
  assign bus.ramstore = r_store;
  assign bus.timeout_err = r_to_err;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: vector table, then
// fetch rotation, starvation, timeout, reset.
module tb_mem_arbiter;
  import cpu_types_pkg::*;

  logic CLK = 1'b0;
  logic RST;

  always #5 CLK = ~CLK;

  mem_arbiter_if bus ();

  mem_arbiter #(
    .STARVE_LIMIT   (4),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  function automatic word_t ram_fn(word_t a);
    return {a[15:0], ~a[15:0]};
  endfunction

  assign bus.ramload = ram_fn(bus.ramaddr);

  typedef struct {
    arb_owner_t own;
    word_t      data;
  } exp_t;

  typedef struct {
    logic [1:0] iren;
    word_t      a0;
    word_t      a1;
    logic       dren;
    logic       dwen;
    word_t      daddr;
    word_t      dstore;
    int         nwait;
    logic       ewen;
    word_t      eaddr;
    word_t      estore;
    arb_owner_t eown;
  } vec_t;

  exp_t sbq[$];
  vec_t vt[10];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc = 0;
  int last_pulse = 0;
  int pulse_gap = 0;

  task automatic chk(
    input string nm,
    input logic [63:0] act,
    input logic [63:0] exp
  );
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h",
               nm, act, exp);
    end
  endtask

  always @(posedge CLK) cyc <= cyc + 1;

  logic [2:0] mon_low;
  exp_t       mon_e;
  arb_owner_t mon_own;
  word_t      mon_data;

  // Scoreboard: pop one entry per completion.
  always @(negedge CLK) begin
    if (!RST) begin
      mon_low = {~bus.dwait, ~bus.iwait};
      if (mon_low != 3'b000) begin
        pulse_gap  = cyc - last_pulse;
        last_pulse = cyc;
        chk("onehot_wait", 64'($countones(mon_low)), 1);
        if (mon_low[2]) begin
          mon_own  = OWN_D;
          mon_data = bus.dload;
        end else if (mon_low[1]) begin
          mon_own  = OWN_I1;
          mon_data = bus.iload[1];
        end else begin
          mon_own  = OWN_I0;
          mon_data = bus.iload[0];
        end
        if (sbq.size() == 0) begin
          chk("sb_unexpected", 64'(mon_low), 0);
        end else begin
          mon_e = sbq.pop_front();
          chk("sb_owner", 64'(mon_own), 64'(mon_e.own));
          chk("sb_data", 64'(mon_data), 64'(mon_e.data));
        end
      end
    end
  end

  task automatic idle_inputs();
    bus.iREN   = 2'b00;
    bus.iaddr  = '0;
    bus.dREN   = 1'b0;
    bus.dWEN   = 1'b0;
    bus.daddr  = '0;
    bus.dstore = '0;
  endtask

  task automatic push(input arb_owner_t o,
                      input word_t a);
    exp_t e;
    e.own  = o;
    e.data = ram_fn(a);
    sbq.push_back(e);
  endtask

  task automatic drain(input string nm);
    int k;
    for (k = 0; k < 60; k++) begin
      @(posedge CLK);
      if (sbq.size() == 0) break;
    end
    chk(nm, 64'(sbq.size()), 0);
    #1;
    idle_inputs();
  endtask

  task automatic wait_access(
    input string nm, output int lat);
    lat = -1;
    for (int k = 0; k < 8; k++) begin
      @(negedge CLK);
      if (bus.ramREN || bus.ramWEN) begin
        lat = k;
        break;
      end
    end
    chk(nm, 64'(lat), 1);
  endtask

  task automatic run_vec(input vec_t v,
                         input int idx);
    int lat;
    string p;
    p = $sformatf("v%0d_", idx);
    @(posedge CLK); #1;
    bus.iREN     = v.iren;
    bus.iaddr[0] = v.a0;
    bus.iaddr[1] = v.a1;
    bus.dREN     = v.dren;
    bus.dWEN     = v.dwen;
    bus.daddr    = v.daddr;
    bus.dstore   = v.dstore;
    bus.ramwait  = (v.nwait != 0);
    push(v.eown, v.eaddr);
    wait_access({p, "lat"}, lat);
    chk({p, "ren"}, 64'(bus.ramREN), 64'(!v.ewen));
    chk({p, "wen"}, 64'(bus.ramWEN), 64'(v.ewen));
    chk({p, "addr"}, 64'(bus.ramaddr), 64'(v.eaddr));
    chk({p, "store"}, 64'(bus.ramstore),
        64'(v.estore));
    if (v.nwait != 0)
      chk({p, "stall"},
          64'({bus.iwait, bus.dwait}), 3'b111);
    for (int w = 0; w < v.nwait; w++) begin
      @(posedge CLK); #1;
      if (v.dwen) bus.dREN = ~bus.dREN;
      if (w == v.nwait - 1) bus.ramwait = 1'b0;
      @(negedge CLK);
      chk({p, "hold_wen"}, 64'(bus.ramWEN),
          64'(v.ewen));
      chk({p, "hold_addr"}, 64'(bus.ramaddr),
          64'(v.eaddr));
      chk({p, "hold_store"}, 64'(bus.ramstore),
          64'(v.estore));
      if (w != v.nwait - 1)
        chk({p, "stall"},
            64'({bus.iwait, bus.dwait}), 3'b111);
    end
    @(posedge CLK); #1;
    idle_inputs();
    bus.ramwait = 1'b1;
    chk({p, "done"}, 64'(sbq.size()), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: no finish");
    $fatal(1);
  end

  initial begin
    int lat;
    vt[0] = '{2'b01, 32'h100, 32'h0, 1'b0, 1'b0,
              32'h0, 32'h0, 0, 1'b0, 32'h100,
              32'h0, OWN_I0};
    vt[1] = '{2'b11, 32'h104, 32'h204, 1'b0, 1'b0,
              32'h0, 32'h0, 1, 1'b0, 32'h204,
              32'h0, OWN_I1};
    vt[2] = '{2'b10, 32'h0, 32'h208, 1'b0, 1'b0,
              32'h0, 32'h0, 0, 1'b0, 32'h208,
              32'h0, OWN_I1};
    vt[3] = '{2'b00, 32'h0, 32'h0, 1'b1, 1'b0,
              32'h300, 32'h0, 2, 1'b0, 32'h300,
              32'h0, OWN_D};
    vt[4] = '{2'b00, 32'h0, 32'h0, 1'b0, 1'b1,
              32'h200, 32'hDEADBEEF, 3, 1'b1,
              32'h200, 32'hDEADBEEF, OWN_D};
    vt[5] = '{2'b00, 32'h0, 32'h0, 1'b1, 1'b1,
              32'h400, 32'h12345678, 1, 1'b1,
              32'h400, 32'h12345678, OWN_D};
    vt[6] = '{2'b11, 32'h110, 32'h210, 1'b1, 1'b0,
              32'h500, 32'h0, 0, 1'b0, 32'h500,
              32'h0, OWN_D};
    vt[7] = '{2'b01, 32'h120, 32'h0, 1'b0, 1'b0,
              32'h0, 32'h0, 2, 1'b0, 32'h120,
              32'h0, OWN_I0};
    vt[8] = '{2'b01, 32'h124, 32'h0, 1'b0, 1'b0,
              32'h0, 32'h0, 0, 1'b0, 32'h124,
              32'h0, OWN_I0};
    vt[9] = '{2'b11, 32'h128, 32'h228, 1'b0, 1'b0,
              32'h0, 32'h0, 1, 1'b0, 32'h228,
              32'h0, OWN_I1};

    RST = 1'b1;
    bus.ramwait = 1'b1;
    idle_inputs();
    #12;
    chk("rst_ren", 64'(bus.ramREN), 0);
    chk("rst_wen", 64'(bus.ramWEN), 0);
    chk("rst_iwait", 64'(bus.iwait), 2'b11);
    chk("rst_dwait", 64'(bus.dwait), 1);
    chk("rst_iload", 64'(bus.iload), 0);
    chk("rst_dload", 64'(bus.dload), 0);
    chk("rst_err", 64'(bus.timeout_err), 0);
    @(posedge CLK); #1;
    RST = 1'b0;

    for (int i = 0; i < 10; i++) run_vec(vt[i], i);

    @(posedge CLK); #1;
    bus.dREN    = 1'b1;
    bus.daddr   = 32'h600;
    bus.ramwait = 1'b1;
    wait_access("to_lat", lat);
    chk("to_start", 64'(bus.timeout_err), 0);
    for (int c = 2; c <= 12; c++) begin
      @(negedge CLK);
      if (c == 8)
        chk("to_before", 64'(bus.timeout_err), 0);
      if (c == 9)
        chk("to_set", 64'(bus.timeout_err), 1);
    end
    chk("to_sticky", 64'(bus.timeout_err), 1);
    chk("to_dwait", 64'(bus.dwait), 1);
    chk("to_ren", 64'(bus.ramREN), 1);

    @(posedge CLK); #1;
    bus.ramwait = 1'b0;
    RST = 1'b1;
    bus.dREN = 1'b0;
    #1;
    chk("mrst_ren", 64'(bus.ramREN), 0);
    chk("mrst_wen", 64'(bus.ramWEN), 0);
    chk("mrst_waits",
        64'({bus.iwait, bus.dwait}), 3'b111);
    chk("mrst_err", 64'(bus.timeout_err), 0);
    @(posedge CLK); #1;
    RST = 1'b0;
    bus.ramwait = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge CLK);
      chk("mrst_idle",
          64'({bus.ramREN, bus.ramWEN}), 0);
    end

    @(posedge CLK); #1;
    bus.iREN     = 2'b11;
    bus.iaddr[0] = 32'h700;
    bus.iaddr[1] = 32'h800;
    bus.ramwait  = 1'b0;
    push(OWN_I0, 32'h700);
    push(OWN_I1, 32'h800);
    push(OWN_I0, 32'h700);
    push(OWN_I1, 32'h800);
    drain("alt_drain");
    chk("alt_gap", 64'(pulse_gap), 2);

    @(posedge CLK); #1;
    bus.iREN     = 2'b01;
    bus.iaddr[0] = 32'h900;
    bus.dREN     = 1'b1;
    bus.daddr    = 32'hA00;
    for (int k = 0; k < 4; k++)
      push(OWN_D, 32'hA00);
    push(OWN_I0, 32'h900);
    push(OWN_D, 32'hA00);
    drain("starve_drain");
    chk("starve_gap", 64'(pulse_gap), 2);

    repeat (3) @(posedge CLK);
    chk("sb_end", 64'(sbq.size()), 0);
    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
